temporal_xmax_n: RTL and testbench

- Clocked, parametrised N-input exclusive-max operator for the temporal (race-logic) datapath.
- Each input carries one event per wave; a wave is bounded by `rst`.
- `q` fires when the last input event of the wave arrives, provided that latest arrival is unique (strictly later than every other input).
- Ties at the latest time, missing inputs, or window expiry suppress the output.
- Successor to the 2-input exclusive max: adds N inputs, a selectable event encoding, a bounded time window, and arrival-time and winner-index outputs.

---
 rtl/temporal_pkg.sv | 21 ++
 rtl/tmp_event_detect.sv | 38 +++
 rtl/temporal_xmax_n.sv | 134 +++++++++++++
 tb/tb_temporal_xmax_n.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/temporal_pkg.sv
// Shared types and helpers for the temporal (race-logic) datapath operators.
package temporal_pkg;

  typedef enum logic [1:0] {
    TMP_RISING,
    TMP_FALLING,
    TMP_PULSE
  } tmp_mode_e;

  typedef enum logic [1:0] {
    ARMED,
    FIRED,
    BLOCKED
  } xmax_state_e;

  // Level a temporal wire rests at when no event has occurred.
  function automatic logic idle_level(tmp_mode_e mode);
    return (mode == TMP_FALLING);
  endfunction

endpackage

// File: rtl/tmp_event_detect.sv
// Per-channel event detector: compares the input against its previous sample
// and flags one new event; events in a wave-reset cycle are discarded.
module tmp_event_detect
  import temporal_pkg::*;
#(
  parameter tmp_mode_e MODE = TMP_RISING
) (
  input  logic aclk,
  input  logic grst,
  input  logic rst,
  input  logic in,
  output logic evt
);

  logic prev;

  // A wave reset reloads prev with the live level, which is the normal update,
  // so levels already held across rst never look like fresh events.
  always_ff @(posedge aclk or negedge grst) begin
    if (!grst) begin
      prev <= idle_level(MODE);
    end else begin
      prev <= in;
    end
  end

  always_comb begin
    evt = 1'b0;
    if (!rst) begin
      if (MODE == TMP_FALLING) begin
        evt = ~in & prev;
      end else begin
        evt = in & ~prev;
      end
    end
  end

endmodule

// File: rtl/temporal_xmax_n.sv
// N-input exclusive-max: fires when the last channel of a wave arrives strictly
// after all others, reporting its wave-relative time and channel index.
module temporal_xmax_n
  import temporal_pkg::*;
#(
  parameter int        N      = 4,
  parameter tmp_mode_e MODE   = TMP_RISING,
  parameter int        WINDOW = 15,
  parameter int        TW     = $clog2(WINDOW + 1),
  parameter int        IW     = $clog2(N)
) (
  input  logic          aclk,
  input  logic          grst,
  input  logic          rst,
  input  logic [N-1:0]  in,
  output logic          q,
  output logic [TW-1:0] q_time,
  output logic [IW-1:0] q_idx,
  output logic          busy
);

  localparam int   PW   = $clog2(N + 1);
  localparam logic IDLE = idle_level(MODE);

  xmax_state_e   state, state_next;
  logic [N-1:0]  evt;
  logic [N-1:0]  arr;
  logic [N-1:0]  fresh;
  logic [N-1:0]  merged;
  logic [TW-1:0] t;
  logic [PW-1:0] pop;
  logic [IW-1:0] win_idx;
  logic          all_in;
  logic          t_max;
  logic          fire;

  for (genvar g = 0; g < N; g++) begin : g_det
    tmp_event_detect #(
      .MODE(MODE)
    ) u_det (
      .aclk(aclk),
      .grst(grst),
      .rst (rst),
      .in  (in[g]),
      .evt (evt[g])
    );
  end

  // Only arrivals not yet seen this wave compete for the max; a single one
  // completing the set is the winner, more than one is a tie.
  always_comb begin
    fresh   = evt & ~arr;
    merged  = arr | evt;
    all_in  = &merged;
    t_max   = (t == TW'(WINDOW));
    pop     = '0;
    win_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (fresh[i]) begin
        pop     = pop + PW'(1);
        win_idx = IW'(i);
      end
    end
  end

  always_ff @(posedge aclk or negedge grst) begin
    if (!grst) begin
      state <= ARMED;
    end else begin
      state <= state_next;
    end
  end

  // Arrivals are merged before the window check, so a last arrival landing
  // exactly on t == WINDOW still wins.
  always_comb begin
    state_next = state;
    fire       = 1'b0;
    if (rst) begin
      state_next = ARMED;
    end else begin
      case (state)
        ARMED: begin
          if (all_in) begin
            if (pop == PW'(1)) begin
              state_next = FIRED;
              fire       = 1'b1;
            end else begin
              state_next = BLOCKED;
            end
          end else if (t_max) begin
            state_next = BLOCKED;
          end
        end
        FIRED:   state_next = FIRED;
        BLOCKED: state_next = BLOCKED;
        default: state_next = ARMED;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge grst) begin
    if (!grst) begin
      arr    <= '0;
      t      <= '0;
      q      <= IDLE;
      q_time <= '0;
      q_idx  <= '0;
    end else if (rst) begin
      arr    <= '0;
      t      <= '0;
      q      <= IDLE;
      q_time <= '0;
      q_idx  <= '0;
    end else begin
      if (state == ARMED) begin
        arr <= merged;
        if (!t_max) begin
          t <= t + 1'b1;
        end
      end
      if (fire) begin
        q      <= ~IDLE;
        q_time <= t;
        q_idx  <= win_idx;
      end else if (state == FIRED && MODE == TMP_PULSE) begin
        q <= IDLE;
      end
    end
  end

  assign busy = (state == ARMED);

endmodule

// File: tb/tb_temporal_xmax_n.sv
// Directed bench: rising, falling and pulse instances share clock and resets.
module tb_temporal_xmax_n;
  import temporal_pkg::*;

  logic       aclk = 1'b0;
  logic       grst = 1'b0;
  logic       rst  = 1'b0;
  logic [3:0] in_r = 4'h0;
  logic [3:0] in_f = 4'hF;

  logic       q_r, q_f, q_p;
  logic [3:0] qt_r, qt_f, qt_p;
  logic [1:0] qi_r, qi_f, qi_p;
  logic       busy_r, busy_f, busy_p;

  int vectors = 0;
  int miscompares = 0;
  int cur_t = 0;

  always #5 aclk = ~aclk;

  temporal_xmax_n #(.N(4), .MODE(TMP_RISING), .WINDOW(15)) dut_r (
    .aclk(aclk), .grst(grst), .rst(rst), .in(in_r),
    .q(q_r), .q_time(qt_r), .q_idx(qi_r), .busy(busy_r));

  temporal_xmax_n #(.N(4), .MODE(TMP_FALLING), .WINDOW(15)) dut_f (
    .aclk(aclk), .grst(grst), .rst(rst), .in(in_f),
    .q(q_f), .q_time(qt_f), .q_idx(qi_f), .busy(busy_f));

  temporal_xmax_n #(.N(4), .MODE(TMP_PULSE), .WINDOW(15)) dut_p (
    .aclk(aclk), .grst(grst), .rst(rst), .in(in_r),
    .q(q_p), .q_time(qt_p), .q_idx(qi_p), .busy(busy_p));

  task automatic checkOutput(input string tag, input int observed, input int expected);
    vectors++;
    if (observed != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Leaves the bench at the falling edge inside the t == 0 cycle.
  task automatic startWave();
    @(negedge aclk);
    rst = 1'b1;
    @(negedge aclk);
    rst = 1'b0;
    cur_t = 0;
  endtask

  task automatic advanceTo(input int k);
    while (cur_t < k) begin
      @(negedge aclk);
      cur_t++;
    end
  endtask

  task automatic applyStimulus(input int k, input int ch);
    advanceTo(k);
    in_r[ch] = 1'b1;
    in_f[ch] = 1'b0;
  endtask

  initial begin
    #12;
    checkOutput("reset q_r", q_r, 0);
    checkOutput("reset q_time", qt_r, 0);
    checkOutput("reset q_idx", qi_r, 0);
    checkOutput("reset busy", busy_r, 1);
    checkOutput("reset q_f", q_f, 1);
    @(negedge aclk);
    grst = 1'b1;

    // 1: unique latest arrival on channel 3 at t9
    startWave();
    applyStimulus(2, 0);
    applyStimulus(4, 1);
    applyStimulus(5, 2);
    checkOutput("s1 q before", q_r, 0);
    applyStimulus(9, 3);
    @(negedge aclk);
    checkOutput("s1 q", q_r, 1);
    checkOutput("s1 q_time", qt_r, 9);
    checkOutput("s1 q_idx", qi_r, 3);
    checkOutput("s1 busy", busy_r, 0);
    checkOutput("s1 pulse high", q_p, 1);
    checkOutput("s1 falling q_time", qt_f, 9);
    @(negedge aclk);
    checkOutput("s1 q held", q_r, 1);
    checkOutput("s1 pulse low", q_p, 0);

    // 2: tie at the max blocks, then rst re-arms
    in_r = 4'h0; in_f = 4'hF;
    startWave();
    applyStimulus(1, 0);
    applyStimulus(3, 1);
    applyStimulus(7, 2);
    in_r[3] = 1'b1; in_f[3] = 1'b0;
    @(negedge aclk);
    checkOutput("s2 q", q_r, 0);
    checkOutput("s2 busy", busy_r, 0);
    checkOutput("s2 pulse q", q_p, 0);
    in_r = 4'h0; in_f = 4'hF;
    startWave();
    checkOutput("s2 rearm busy", busy_r, 1);

    // 3a: channel 3 never arrives, window expires
    applyStimulus(1, 0);
    applyStimulus(2, 1);
    applyStimulus(3, 2);
    advanceTo(15);
    checkOutput("s3a busy at t15", busy_r, 1);
    @(negedge aclk);
    checkOutput("s3a busy", busy_r, 0);
    checkOutput("s3a q", q_r, 0);

    // 3b: last arrival exactly on the window boundary
    in_r = 4'h0; in_f = 4'hF;
    startWave();
    applyStimulus(1, 0);
    applyStimulus(2, 1);
    applyStimulus(3, 2);
    applyStimulus(15, 3);
    @(negedge aclk);
    checkOutput("s3b q", q_r, 1);
    checkOutput("s3b q_time", qt_r, 15);
    checkOutput("s3b q_idx", qi_r, 3);

    // 4: falling and pulse encodings, falls at t1 t2 t3 t6
    in_r = 4'h0; in_f = 4'hF;
    startWave();
    applyStimulus(1, 0);
    applyStimulus(2, 1);
    applyStimulus(3, 2);
    checkOutput("s4 q_f before", q_f, 1);
    applyStimulus(6, 3);
    @(negedge aclk);
    checkOutput("s4 q_f", q_f, 0);
    checkOutput("s4 q_f idx", qi_f, 3);
    checkOutput("s4 q_f time", qt_f, 6);
    checkOutput("s4 pulse high", q_p, 1);
    checkOutput("s4 pulse idx", qi_p, 3);
    @(negedge aclk);
    checkOutput("s4 pulse low", q_p, 0);
    checkOutput("s4 q_f held", q_f, 0);
    @(negedge aclk);
    checkOutput("s4 pulse stays low", q_p, 0);

    // 5: rst mid-wave while channel 1 is held high
    in_r = 4'h0; in_f = 4'hF;
    startWave();
    applyStimulus(2, 1);
    advanceTo(4);
    startWave();
    applyStimulus(1, 0);
    applyStimulus(2, 2);
    applyStimulus(3, 3);
    advanceTo(15);
    checkOutput("s5 q before expiry", q_r, 0);
    checkOutput("s5 busy at t15", busy_r, 1);
    @(negedge aclk);
    checkOutput("s5 busy", busy_r, 0);
    checkOutput("s5 q", q_r, 0);

    // 6: asynchronous global reset while FIRED
    in_r = 4'h0; in_f = 4'hF;
    startWave();
    applyStimulus(1, 0);
    applyStimulus(2, 1);
    applyStimulus(3, 2);
    applyStimulus(4, 3);
    @(negedge aclk);
    checkOutput("s6 fired", q_r, 1);
    #1 grst = 1'b0;
    #1;
    checkOutput("s6 grst q", q_r, 0);
    checkOutput("s6 grst q_time", qt_r, 0);
    checkOutput("s6 grst busy", busy_r, 1);
    checkOutput("s6 grst q_f", q_f, 1);
    #1 grst = 1'b1;
    @(negedge aclk);
    in_r = 4'h0; in_f = 4'hF;
    startWave();
    applyStimulus(1, 0);
    in_r[1] = 1'b1; in_f[1] = 1'b0;
    applyStimulus(2, 2);
    applyStimulus(5, 3);
    @(negedge aclk);
    checkOutput("s6 fresh q", q_r, 1);
    checkOutput("s6 fresh q_time", qt_r, 5);
    checkOutput("s6 fresh q_idx", qi_r, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
